// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle control unit for the MIPS-subset CPU.
// Sequences IF/ID/EX/MEM/WB, handshakes with a variable-latency memory through
// i_mem_ready, and counts retired instructions.
// Optional feature macro: MC_ILLEGAL_TRAP_EN
//   defined     -> undecodable instructions enter TRAP and hold until reset
//   not defined -> undecodable instructions retire as a NOP, o_illegal tied 0
// Datapath controls are registered from the next state. The IF fetch strobes
// (IR/PC write, PC+4 select) are Mealy on i_mem_ready.
// ST_W must be at least 4.
module mc_ctrl_fsm #(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned ST_W  = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [31:0]      i_instruction,
   input  logic             i_mem_ready,
   output logic             o_pc_we,
   output logic [1:0]       o_pc_src,
   output logic             o_mem_in,
   output logic             o_mem_re,
   output logic             o_mem_we,
   output logic             o_ir_we,
   output logic             o_a_we,
   output logic             o_b_we,
   output logic             o_alu_src_a,
   output logic [2:0]       o_alu_src_b,
   output logic [2:0]       o_alu_op,
   output logic             o_dst,
   output logic             o_reg_in,
   output logic             o_reg_we,
   output logic             o_branch,
   output logic             o_branch_ne,
   output logic             o_jal,
   output logic [CNT_W-1:0] o_retired,
   output logic [ST_W-1:0]  o_state,
   output logic             o_illegal
);

   typedef enum logic [3:0] {
      StIf     = 4'd0,
      StId     = 4'd1,
      StExAddr = 4'd2,
      StMemLw  = 4'd3,
      StWbLw   = 4'd4,
      StMemSw  = 4'd5,
      StExR    = 4'd6,
      StWbR    = 4'd7,
      StExI    = 4'd8,
      StWbI    = 4'd9,
      StExBr   = 4'd10,
      StJ      = 4'd11,
      StJal    = 4'd12,
      StJr     = 4'd13,
      StTrap   = 4'd14
   } state_e;

   // Opcodes
   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpJ     = 6'h02;
   localparam logic [5:0] OpJal   = 6'h03;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpBne   = 6'h05;
   localparam logic [5:0] OpAddi  = 6'h08;
   localparam logic [5:0] OpXori  = 6'h0E;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;

   // R-type funct codes
   localparam logic [5:0] FnJr    = 6'h08;
   localparam logic [5:0] FnAdd   = 6'h20;
   localparam logic [5:0] FnSub   = 6'h22;
   localparam logic [5:0] FnSlt   = 6'h2A;

   // ALU operand B selects
   localparam logic [2:0] SrcBReg    = 3'b000;
   localparam logic [2:0] SrcBFour   = 3'b001;
   localparam logic [2:0] SrcBSext   = 3'b010;
   localparam logic [2:0] SrcBSextSh = 3'b011;
   localparam logic [2:0] SrcBZext   = 3'b100;

   // ALU operations
   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluXor = 3'b010;
   localparam logic [2:0] AluSlt = 3'b011;

   // PC sources
   localparam logic [1:0] PcAluOut = 2'b01;
   localparam logic [1:0] PcJump   = 2'b10;
   localparam logic [1:0] PcAReg   = 2'b11;

   state_e           r_state;
   logic [CNT_W-1:0] r_retired;
   logic             r_pc_we;
   logic [1:0]       r_pc_src;
   logic             r_mem_in;
   logic             r_mem_re;
   logic             r_mem_we;
   logic             r_a_we;
   logic             r_b_we;
   logic             r_alu_src_a;
   logic [2:0]       r_alu_src_b;
   logic [2:0]       r_alu_op;
   logic             r_dst;
   logic             r_reg_in;
   logic             r_reg_we;
   logic             r_branch;
   logic             r_branch_ne;
   logic             r_jal;
`ifdef MC_ILLEGAL_TRAP_EN
   logic             r_illegal;
`endif

   state_e     w_state_d;
   state_e     w_dec_state;
   logic       w_dec_legal;
   logic       w_retire;
   logic       w_if_fire;
   logic [5:0] w_opcode;
   logic [5:0] w_funct;
   logic       w_unused_instr;

   assign w_opcode       = i_instruction[31:26];
   assign w_funct        = i_instruction[5:0];
   // Register and immediate fields are consumed by the datapath, not here.
   assign w_unused_instr = ^i_instruction[25:6];

   // Fetch completes only once the read request is actually on the bus; right
   // after reset the request is still low for one cycle.
   assign w_if_fire = (r_state == StIf) && r_mem_re && i_mem_ready;

   // Decode the IR into the first execute state of the instruction.
   always_comb begin
      w_dec_state = StIf;
      w_dec_legal = 1'b1;
      case (w_opcode)
         OpLw, OpSw:     w_dec_state = StExAddr;
         OpAddi, OpXori: w_dec_state = StExI;
         OpBeq, OpBne:   w_dec_state = StExBr;
         OpJ:            w_dec_state = StJ;
         OpJal:          w_dec_state = StJal;
         OpRtype: begin
            case (w_funct)
               FnJr:                w_dec_state = StJr;
               FnAdd, FnSub, FnSlt: w_dec_state = StExR;
               default:             w_dec_legal = 1'b0;
            endcase
         end
         default:        w_dec_legal = 1'b0;
      endcase
   end

   // Next-state and retire decision.
   always_comb begin
      w_state_d = r_state;
      w_retire  = 1'b0;
      case (r_state)
         StIf: begin
            if (w_if_fire) begin
               w_state_d = StId;
            end
         end
         StId: begin
            if (w_dec_legal) begin
               w_state_d = w_dec_state;
            end else begin
`ifdef MC_ILLEGAL_TRAP_EN
               w_state_d = StTrap;
`else
               w_state_d = StIf;
               w_retire  = 1'b1;
`endif
            end
         end
         StExAddr: w_state_d = (w_opcode == OpLw) ? StMemLw : StMemSw;
         StMemLw: begin
            if (i_mem_ready) begin
               w_state_d = StWbLw;
            end
         end
         StMemSw: begin
            if (i_mem_ready) begin
               w_state_d = StIf;
               w_retire  = 1'b1;
            end
         end
         StExR:    w_state_d = StWbR;
         StExI:    w_state_d = StWbI;
         StWbLw, StWbR, StWbI, StExBr, StJ, StJal, StJr: begin
            w_state_d = StIf;
            w_retire  = 1'b1;
         end
         StTrap:   w_state_d = StTrap;
         default:  w_state_d = StIf;
      endcase
   end

   // State, retire counter and registered controls for the state being entered.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StIf;
         r_retired   <= '0;
         r_pc_we     <= 1'b0;
         r_pc_src    <= 2'b00;
         r_mem_in    <= 1'b0;
         r_mem_re    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_a_we      <= 1'b0;
         r_b_we      <= 1'b0;
         r_alu_src_a <= 1'b0;
         r_alu_src_b <= SrcBReg;
         r_alu_op    <= AluAdd;
         r_dst       <= 1'b0;
         r_reg_in    <= 1'b0;
         r_reg_we    <= 1'b0;
         r_branch    <= 1'b0;
         r_branch_ne <= 1'b0;
         r_jal       <= 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
         r_illegal   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_d;
         if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
         end

         r_pc_we     <= 1'b0;
         r_pc_src    <= 2'b00;
         r_mem_in    <= 1'b0;
         r_mem_re    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_a_we      <= 1'b0;
         r_b_we      <= 1'b0;
         r_alu_src_a <= 1'b0;
         r_alu_src_b <= SrcBReg;
         r_alu_op    <= AluAdd;
         r_dst       <= 1'b0;
         r_reg_in    <= 1'b0;
         r_reg_we    <= 1'b0;
         r_branch    <= 1'b0;
         r_branch_ne <= 1'b0;
         r_jal       <= 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
         r_illegal   <= 1'b0;
`endif

         case (w_state_d)
            StIf: begin
               r_mem_re <= 1'b1;
            end
            StId: begin
               // Latch A/B and precompute the branch target into ALUOut.
               r_a_we      <= 1'b1;
               r_b_we      <= 1'b1;
               r_alu_src_b <= SrcBSextSh;
            end
            StExAddr: begin
               r_alu_src_a <= 1'b1;
               r_alu_src_b <= SrcBSext;
            end
            StMemLw: begin
               r_mem_re <= 1'b1;
               r_mem_in <= 1'b1;
            end
            StWbLw: begin
               r_reg_we <= 1'b1;
               r_reg_in <= 1'b1;
            end
            StMemSw: begin
               r_mem_we <= 1'b1;
               r_mem_in <= 1'b1;
            end
            StExR: begin
               r_alu_src_a <= 1'b1;
               case (w_funct)
                  FnSub:   r_alu_op <= AluSub;
                  FnSlt:   r_alu_op <= AluSlt;
                  default: r_alu_op <= AluAdd;
               endcase
            end
            StWbR: begin
               r_reg_we <= 1'b1;
               r_dst    <= 1'b1;
            end
            StExI: begin
               r_alu_src_a <= 1'b1;
               if (w_opcode == OpXori) begin
                  r_alu_src_b <= SrcBZext;
                  r_alu_op    <= AluXor;
               end else begin
                  r_alu_src_b <= SrcBSext;
               end
            end
            StWbI: begin
               r_reg_we <= 1'b1;
            end
            StExBr: begin
               r_alu_src_a <= 1'b1;
               r_alu_op    <= AluSub;
               r_branch    <= 1'b1;
               r_branch_ne <= (w_opcode == OpBne);
               r_pc_src    <= PcAluOut;
            end
            StJ: begin
               r_pc_we  <= 1'b1;
               r_pc_src <= PcJump;
            end
            StJal: begin
               r_pc_we  <= 1'b1;
               r_pc_src <= PcJump;
               r_reg_we <= 1'b1;
               r_jal    <= 1'b1;
            end
            StJr: begin
               r_pc_we  <= 1'b1;
               r_pc_src <= PcAReg;
            end
            StTrap: begin
`ifdef MC_ILLEGAL_TRAP_EN
               r_illegal <= 1'b1;
`endif
            end
            default: begin
            end
         endcase
      end
   end

   // Fetch strobes overlay the registered controls while IF completes.
   assign o_ir_we     = w_if_fire;
   assign o_pc_we     = r_pc_we | w_if_fire;
   assign o_pc_src    = r_pc_src;
   assign o_alu_src_b = w_if_fire ? SrcBFour : r_alu_src_b;

   assign o_mem_in    = r_mem_in;
   assign o_mem_re    = r_mem_re;
   assign o_mem_we    = r_mem_we;
   assign o_a_we      = r_a_we;
   assign o_b_we      = r_b_we;
   assign o_alu_src_a = r_alu_src_a;
   assign o_alu_op    = r_alu_op;
   assign o_dst       = r_dst;
   assign o_reg_in    = r_reg_in;
   assign o_reg_we    = r_reg_we;
   assign o_branch    = r_branch;
   assign o_branch_ne = r_branch_ne;
   assign o_jal       = r_jal;
   assign o_retired   = r_retired;
   assign o_state     = ST_W'(r_state);

`ifdef MC_ILLEGAL_TRAP_EN
   assign o_illegal = r_illegal;
`else
   assign o_illegal = 1'b0;
`endif

endmodule
